// File: rtl/seq_game_pkg.sv
// Shared types and LFSR tap constants for the sequence-game engine.
package seq_game_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, INPUT, OVER} state_t;
    typedef enum logic {PH_SHOW, PH_GAP} phase_t;

    localparam logic [15:0] LFSR16_TAPS = 16'hB400;

    // Right-shifting Galois tap masks; widths without an entry fall back to the 16-bit mask.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            4:       return 32'h0000_000C;
            8:       return 32'h0000_00B8;
            16:      return {16'h0000, LFSR16_TAPS};
            default: return {16'h0000, LFSR16_TAPS};
        endcase
    endfunction

endpackage

// File: rtl/seq_lfsr.sv
// Right-shifting Galois LFSR with synchronous load and step enable; resets to 1.
module seq_lfsr #(
    parameter int            W    = 16,
    parameter logic [W-1:0]  TAPS = W'(16'hB400)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;
    logic [W-1:0] step_val;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            if (gi == W - 1) begin : g_top
                assign step_val[gi] = q_reg[0] & TAPS[gi];
            end else begin : g_mid
                assign step_val[gi] = q_reg[gi+1] ^ (q_reg[0] & TAPS[gi]);
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg <= W'(1);
        end else if (load) begin
            q_reg <= load_val;
        end else if (step) begin
            q_reg <= step_val;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/seq_game_core.sv
// Simon-style memory game: replays an LFSR-generated symbol sequence, then
// checks the player's entries, growing the round by one symbol on success.
module seq_game_core
    import seq_game_pkg::*;
#(
    parameter int SYM_W        = 2,
    parameter int MAX_LEN      = 16,
    parameter int SHOW_CYCLES  = 25_000_000,
    parameter int GAP_CYCLES   = 5_000_000,
    parameter int MAX_MISTAKES = 3,
    parameter int SCORE_W      = 8,
    parameter int LFSR_W       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [SYM_W-1:0]             sym_in,
    input  logic                         sym_valid,
    output logic [SYM_W-1:0]             show_sym,
    output logic                         show_valid,
    output logic                         await_input,
    output logic [$clog2(MAX_LEN+1)-1:0] round_len,
    output logic [SCORE_W-1:0]           score,
    output logic [SCORE_W-1:0]           mistakes,
    output logic                         game_over,
    output logic                         won
);

    localparam int RL_W    = $clog2(MAX_LEN + 1);
    localparam int CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [CNT_W-1:0]  SHOW_LOAD = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t              state_reg, state_next;
    phase_t              phase_reg, phase_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [RL_W-1:0]     idx_reg, idx_next;
    logic [RL_W-1:0]     len_reg, len_next;
    logic [SCORE_W-1:0]  score_reg, score_next;
    logic [SCORE_W-1:0]  mistakes_reg, mistakes_next;
    logic                won_reg, won_next;
    logic [LFSR_W-1:0]   seed_reg, seed_next;

    logic [LFSR_W-1:0]   free_q;
    logic [LFSR_W-1:0]   gen_q;
    logic [LFSR_W-1:0]   gen_load_val;
    logic [LFSR_W-1:0]   start_seed;
    logic                gen_load;
    logic                gen_step;
    logic                replay;
    logic                gen_unused;

    seq_lfsr #(.W(LFSR_W), .TAPS(TAPS)) u_free_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (1'b0),
        .load_val ('0),
        .step     (1'b1),
        .q        (free_q)
    );

    seq_lfsr #(.W(LFSR_W), .TAPS(TAPS)) u_gen_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (gen_load),
        .load_val (gen_load_val),
        .step     (gen_step),
        .q        (gen_q)
    );

    // Only the low symbol bits of the generator are consumed.
    assign gen_unused = ^gen_q;
    assign start_seed = (free_q == '0) ? LFSR_W'(1) : free_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            phase_reg    <= PH_SHOW;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            len_reg      <= '0;
            score_reg    <= '0;
            mistakes_reg <= '0;
            won_reg      <= 1'b0;
            seed_reg     <= LFSR_W'(1);
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            len_reg      <= len_next;
            score_reg    <= score_next;
            mistakes_reg <= mistakes_next;
            won_reg      <= won_next;
            seed_reg     <= seed_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        cnt_next      = cnt_reg;
        idx_next      = idx_reg;
        len_next      = len_reg;
        score_next    = score_reg;
        mistakes_next = mistakes_reg;
        won_next      = won_reg;
        seed_next     = seed_reg;
        gen_load      = 1'b0;
        gen_load_val  = seed_reg;
        gen_step      = 1'b0;
        replay        = 1'b0;

        case (state_reg)
            IDLE, OVER: begin
                if (start) begin
                    seed_next     = start_seed;
                    gen_load_val  = start_seed;
                    score_next    = '0;
                    mistakes_next = '0;
                    won_next      = 1'b0;
                    len_next      = RL_W'(1);
                    replay        = 1'b1;
                end
            end
            SHOW: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (phase_reg == PH_SHOW) begin
                    phase_next = PH_GAP;
                    cnt_next   = GAP_LOAD;
                end else if (idx_reg == len_reg - 1'b1) begin
                    state_next = INPUT;
                    idx_next   = '0;
                    gen_load   = 1'b1;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                    gen_step   = 1'b1;
                    phase_next = PH_SHOW;
                    cnt_next   = SHOW_LOAD;
                end
            end
            INPUT: begin
                if (sym_valid) begin
                    if (sym_in == gen_q[SYM_W-1:0]) begin
                        if (idx_reg < len_reg - 1'b1) begin
                            idx_next = idx_reg + 1'b1;
                            gen_step = 1'b1;
                        end else begin
                            if (score_reg != '1) begin
                                score_next = score_reg + 1'b1;
                            end
                            if (len_reg == RL_W'(MAX_LEN)) begin
                                state_next = OVER;
                                won_next   = 1'b1;
                            end else begin
                                len_next = len_reg + 1'b1;
                                replay   = 1'b1;
                            end
                        end
                    end else begin
                        mistakes_next = mistakes_reg + 1'b1;
                        if (mistakes_next == SCORE_W'(MAX_MISTAKES)) begin
                            state_next = OVER;
                            won_next   = 1'b0;
                        end else begin
                            replay = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase

        // Every new round, retry or fresh game replays from the first symbol.
        if (replay) begin
            state_next = SHOW;
            phase_next = PH_SHOW;
            cnt_next   = SHOW_LOAD;
            idx_next   = '0;
            gen_load   = 1'b1;
        end
    end

    always_comb begin
        show_valid  = (state_reg == SHOW) && (phase_reg == PH_SHOW);
        show_sym    = show_valid ? gen_q[SYM_W-1:0] : '0;
        await_input = (state_reg == INPUT);
        game_over   = (state_reg == OVER);
        round_len   = len_reg;
        score       = score_reg;
        mistakes    = mistakes_reg;
        won         = won_reg;
    end

endmodule

// File: tb/tb_seq_game_core.sv
// Randomized bench for seq_game_core against a rule-level game model.
module tb_seq_game_core;

    localparam int SYM_W    = 2;
    localparam int MAX_LEN  = 3;
    localparam int SHOW_C   = 4;
    localparam int GAP_C    = 2;
    localparam int MAX_MIST = 2;
    localparam int SCORE_W  = 8;
    localparam int LFSR_W   = 16;
    localparam int RL_W     = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [SYM_W-1:0]   sym_in;
    logic               sym_valid;
    logic [SYM_W-1:0]   show_sym;
    logic               show_valid;
    logic               await_input;
    logic [RL_W-1:0]    round_len;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] mistakes;
    logic               game_over;
    logic               won;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] free_m, seed_cand, exp_seed;
    int          len_m, idx_m, score_m, mistakes_m;
    bit          won_m, over_m, poke_start;

    always #5 clk = ~clk;

    seq_game_core #(
        .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW_C), .GAP_CYCLES(GAP_C),
        .MAX_MISTAKES(MAX_MIST), .SCORE_W(SCORE_W), .LFSR_W(LFSR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .sym_in(sym_in), .sym_valid(sym_valid),
        .show_sym(show_sym), .show_valid(show_valid), .await_input(await_input),
        .round_len(round_len), .score(score), .mistakes(mistakes),
        .game_over(game_over), .won(won)
    );

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Free-running generator value seen by the design on each edge where start is high.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            free_m    <= 16'h0001;
            seed_cand <= 16'h0001;
        end else begin
            if (start) seed_cand <= free_m;
            free_m <= lfsr_next(free_m);
        end
    end

    function automatic logic [1:0] sym_at(input int i);
        logic [15:0] x;
        x = exp_seed;
        for (int k = 0; k < i; k++) x = lfsr_next(x);
        return x[1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".round_len"}, round_len, len_m);
        check({tag, ".score"}, score, score_m);
        check({tag, ".mistakes"}, mistakes, mistakes_m);
        check({tag, ".game_over"}, game_over, over_m);
        check({tag, ".won"}, won, won_m);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".show_sym"}, show_sym, 0);
        check({tag, ".show_valid"}, show_valid, 0);
        check({tag, ".await_input"}, await_input, 0);
        check({tag, ".round_len"}, round_len, 0);
        check({tag, ".score"}, score, 0);
        check({tag, ".mistakes"}, mistakes, 0);
        check({tag, ".game_over"}, game_over, 0);
        check({tag, ".won"}, won, 0);
    endtask

    // Called in the first cycle of a SHOW phase; walks it and lands in the first INPUT cycle.
    task automatic watch_show();
        logic [1:0] e;
        bit         on;
        for (int i = 0; i < len_m; i++) begin
            e = sym_at(i);
            for (int c = 0; c < SHOW_C + GAP_C; c++) begin
                on = (c < SHOW_C);
                check("show_valid", show_valid, on);
                check("show_sym", show_sym, on ? e : 2'd0);
                check("await_in_show", await_input, 0);
                if (poke_start && i == 0 && c == 1) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        if (poke_start) begin
            poke_start = 1'b0;
            check_state("start_in_show");
        end
        check("await_rise", await_input, 1);
        check("show_after", show_valid, 0);
        $display("show   len=%0d seed=%04h", len_m, exp_seed);
    endtask

    task automatic do_start(input bit with_valid);
        start     = 1'b1;
        sym_valid = with_valid;
        sym_in    = SYM_W'($urandom);
        tick();
        start     = 1'b0;
        sym_valid = 1'b0;
        exp_seed  = (seed_cand == 16'h0) ? 16'h0001 : seed_cand;
        len_m = 1; idx_m = 0; score_m = 0; mistakes_m = 0; won_m = 0; over_m = 0;
        $display("start  seed=%04h valid_too=%0d", exp_seed, with_valid);
        check_state("start");
        watch_show();
    endtask

    task automatic submit(input logic [1:0] s);
        logic [1:0] e;
        bit         to_show;
        e       = sym_at(idx_m);
        to_show = 1'b0;
        sym_in    = s;
        sym_valid = 1'b1;
        tick();
        sym_valid = 1'b0;
        if (s == e) begin
            if (idx_m < len_m - 1) begin
                idx_m++;
            end else begin
                score_m = (score_m == 255) ? 255 : score_m + 1;
                if (len_m == MAX_LEN) begin
                    over_m = 1; won_m = 1;
                end else begin
                    len_m++; to_show = 1;
                end
            end
        end else begin
            mistakes_m++;
            if (mistakes_m == MAX_MIST) begin
                over_m = 1; won_m = 0;
            end else begin
                to_show = 1;
            end
        end
        $display("submit sym=%0d want=%0d len=%0d score=%0d mistakes=%0d over=%0d",
                 s, e, len_m, score_m, mistakes_m, over_m);
        check_state("submit");
        check("submit.await", await_input, !over_m && !to_show);
        if (to_show) begin
            idx_m = 0;
            watch_show();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] w;
        int         bound;
        reset = 1'b1; start = 1'b0; sym_valid = 1'b0; sym_in = '0; poke_start = 1'b0;
        repeat (3) tick();
        check_reset("reset_held");
        #2 reset = 1'b0;
        tick();
        check_reset("idle");
        repeat ($urandom_range(1, 20)) tick();

        // Win: echo all three rounds; a start pulse during round-2 replay must be ignored.
        do_start(1'b0);
        poke_start = 1'b1;
        while (!over_m) submit(sym_at(idx_m));
        check("win.won", won, 1);
        check("win.score", score, 3);

        // start together with sym_valid in OVER starts a new game.
        repeat ($urandom_range(0, 7)) tick();
        do_start(1'b1);
        submit(sym_at(0));
        if ($urandom_range(0, 1) == 1) submit(sym_at(0));
        w = sym_at(idx_m) + 2'($urandom_range(1, 3));
        submit(w);
        check("retry.round_len", round_len, 2);
        submit(sym_at(0));
        w = sym_at(idx_m) + 2'($urandom_range(1, 3));
        submit(w);
        check("lose.won", won, 0);
        check("lose.mistakes", mistakes, 2);
        for (int p = 0; p < 3; p++) begin
            sym_in    = SYM_W'($urandom);
            sym_valid = 1'b1;
            tick();
            sym_valid = 1'b0;
            $display("pulse  in OVER sym=%0d", sym_in);
            check_state("over_hold");
            check("over_hold.show_valid", show_valid, 0);
        end

        // Asynchronous reset in the middle of INPUT.
        do_start(1'b0);
        submit(sym_at(0));
        #2 reset = 1'b1;
        #1 check_reset("async_reset");
        #3 reset = 1'b0;
        tick();
        check_reset("after_reset");
        $display("reset  asserted mid-INPUT");

        // Random games from the rule-level model.
        for (int g = 0; g < 5; g++) begin
            repeat ($urandom_range(0, 15)) tick();
            do_start(1'b0);
            bound = 0;
            while (!over_m && bound < 40) begin
                w = sym_at(idx_m);
                if ($urandom_range(0, 3) == 0) w = w + 2'($urandom_range(1, 3));
                submit(w);
                bound++;
            end
            check("game_end", game_over, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
